wb_fir_engine: RTL and testbench
================================

WB_FIR_ENGINE -- requirements
Module: wb_fir_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32, sample/coefficient/result width.
REQ-002 SHALL have parameter NTAP, default 11, tap count (range 2..32).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h3000_0000, 256-byte window base.
REQ-004 SHALL have port wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port wb_rst_i  in  1  synchronous, active-low reset (0 = reset).
REQ-006 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone cycle, strobe, write.
REQ-007 SHALL have port wbs_sel_i  in  4  byte select, ignored; all writes are full-word.
REQ-008 SHALL have ports wbs_adr_i, wbs_dat_i  in  32 each  address, write data.
REQ-009 SHALL have ports wbs_ack_o  out  1, wbs_dat_o  out  32  acknowledge, read data.
REQ-010 SHALL have port irq_o  out  1  high while ap_done is set.

Function
REQ-011 Register map, byte offsets: 0x00 CTRL, 0x10 LEN, 0x40+4*i COEF[i] (i<NTAP), 0x80 X (write), 0x84 Y (read).
REQ-012 Selected = cyc&stb and wbs_adr_i[31:8]==BASE_ADDR[31:8]; unselected, wbs_ack_o and wbs_dat_o stay 0.
REQ-013 Ack: one-cycle pulse, earliest the cycle after selection; never asserted twice per transfer; wbs_dat_o valid only while ack high, 0 otherwise.
REQ-014 CTRL bits: [0] ap_start (W1; reads 0), [1] ap_done (RO, cleared by CTRL read), [2] ap_idle (RO), [4] x_ready (RO), [5] y_valid (RO); other bits read 0.
REQ-015 LEN and COEF writable/readable only while ap_idle; writes while busy are acked and discarded.
REQ-016 Unmapped offsets inside the window: ack, read 0, writes ignored.
REQ-017 States: IDLE, WAIT_X, MAC, WAIT_Y, DONE.
REQ-018 IDLE: ap_idle=1; ap_start write with LEN>0 clears sample history (NTAP regs) and counter, clears ap_done, -> WAIT_X; with LEN=0 -> DONE.
REQ-019 WAIT_X: x_ready=1; X write acked in 1 wait state, shifts sample into history[0], -> MAC.
REQ-020 X write outside WAIT_X: ack withheld (stall) until WAIT_X is reached, then accepted per REQ-019; in IDLE/DONE, acked and discarded.
REQ-021 MAC: one tap per cycle, NTAP cycles, acc += COEF[i]*history[i]; signed two's complement; product and sum truncated to low DATA_W bits (wrap, no saturation); -> WAIT_Y with y_valid=1.
REQ-022 X-accept ack to y_valid: exactly NTAP+1 cycles.
REQ-023 Y read outside WAIT_Y: ack withheld until y_valid, then returns the result; in IDLE/DONE, acked, returns last result.
REQ-024 WAIT_Y: Y read acked, y_valid cleared, counter++; counter==LEN -> DONE, else -> WAIT_X.
REQ-025 DONE: sets ap_done=1, -> IDLE next cycle; ap_done holds until CTRL read.
REQ-026 ap_start written while not idle: ignored.
REQ-027 CTRL read in the same cycle ap_done sets: ap_done remains set (set wins).
REQ-028 Counter and LEN DATA_W wide; counter never wraps within a job.

Reset
REQ-029 While wb_rst_i=0 at a clock edge: state=IDLE, wbs_ack_o=0, wbs_dat_o=0, irq_o=0, ap_done=0, y_valid=0, counter=0, history=0, LEN=0, COEF[*]=0, result=0.
REQ-030 Reset mid-transfer or mid-job aborts without ack; first transfer after release is handled normally.

Verification
REQ-031 Reset, read CTRL -> 0x0000_0004; read LEN, COEF[0] -> 0.
REQ-032 NTAP=11, COEF=0..10, LEN=5, X=1..5 -> Y=0,1,4,10,20; then CTRL read -> ap_done=1, irq_o falls after read.
REQ-033 COEF[0]=32'h7FFF_FFFF, others 0, X=2 -> Y=32'hFFFF_FFFE (wrap); COEF[0]=-1, X=3 -> Y=32'hFFFF_FFFD.
REQ-034 Issue Y read right after X write -> ack withheld, arrives with correct Y; X->y_valid exactly 12 cycles for NTAP=11.
REQ-035 During job write COEF[0]=99 and ap_start -> both acked, COEF[0] unchanged, job continues; LEN=0 start -> ap_done within 2 cycles.
REQ-036 Assert reset mid-MAC, release, run REQ-032 job -> identical results, no spurious ack.

Source files
------------

// File: rtl/wb_fir_engine.sv
// rtl/wb_fir_engine.sv - Wishbone-mapped sequential FIR multiply-accumulate engine
module wb_fir_engine #(
   parameter int          DATA_W    = 32,
   parameter int          NTAP      = 11,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        irq_o
);
   localparam int IDX_W = (NTAP > 1) ? $clog2(NTAP) : 1;
   localparam int TAP_W = $clog2(NTAP + 1);
   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NTAP);
   localparam logic [5:0]       NTAP_W6  = 6'(NTAP);

   typedef enum logic [2:0] {S_IDLE, S_WAIT_X, S_MAC, S_WAIT_Y, S_DONE} state_t;

   state_t            state, state_nxt;
   logic              ap_done;
   logic [DATA_W-1:0] len, cnt, acc, result, prod;
   logic [DATA_W-1:0] coef [NTAP];
   logic [DATA_W-1:0] hist [NTAP];
   logic [TAP_W-1:0]  tap;
   logic [5:0]        word, coef_off;
   logic [IDX_W-1:0]  coef_idx, tap_idx;
   logic              sel, hit_ctrl, hit_len, hit_coef, hit_x, hit_y;
   logic              ap_idle, x_ready, y_valid, stall, accept;
   logic              start, x_take, y_take, ctrl_rd, len_wr, coef_wr;
   logic [31:0]       rdata;
   logic              unused_ok;

   assign sel      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign word     = wbs_adr_i[7:2];
   assign coef_off = word - 6'd16;
   assign coef_idx = coef_off[IDX_W-1:0];
   assign tap_idx  = tap[IDX_W-1:0];
   assign hit_ctrl = (word == 6'd0);
   assign hit_len  = (word == 6'd4);
   assign hit_x    = (word == 6'd32);
   assign hit_y    = (word == 6'd33);
   assign hit_coef = (word >= 6'd16) && (coef_off < NTAP_W6) && !hit_x && !hit_y;

   assign ap_idle  = (state == S_IDLE);
   assign x_ready  = (state == S_WAIT_X);
   assign y_valid  = (state == S_WAIT_Y);

   // X writes wait for WAIT_X and Y reads wait for the result while a job is mid-flight
   assign stall    = (hit_x && wbs_we_i && (state == S_MAC || state == S_WAIT_Y))
                  || (hit_y && !wbs_we_i && (state == S_WAIT_X || state == S_MAC));
   assign accept   = sel && !wbs_ack_o && !stall;
   assign start    = accept && wbs_we_i && hit_ctrl && wbs_dat_i[0] && ap_idle;
   assign x_take   = accept && wbs_we_i && hit_x && x_ready;
   assign y_take   = accept && !wbs_we_i && hit_y && y_valid;
   assign ctrl_rd  = accept && !wbs_we_i && hit_ctrl;
   assign len_wr   = accept && wbs_we_i && hit_len && ap_idle;
   assign coef_wr  = accept && wbs_we_i && hit_coef && ap_idle;

   assign prod      = coef[tap_idx] * hist[tap_idx];
   assign irq_o     = ap_done;
   assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0]};

   // Read data mux; LEN and COEF are hidden while a job runs
   always_comb begin
      rdata = '0;
      if (hit_ctrl)
         rdata = {26'd0, y_valid, x_ready, 1'b0, ap_idle, ap_done, 1'b0};
      else if (hit_len && ap_idle)
         rdata = 32'(len);
      else if (hit_coef && ap_idle)
         rdata = 32'(coef[coef_idx]);
      else if (hit_y)
         rdata = 32'(result);
   end

   // Job sequencing: one sample in, NTAP taps plus a result write-back, one result out
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = (len != '0) ? S_WAIT_X : S_DONE;
         S_WAIT_X: if (x_take) state_nxt = S_MAC;
         S_MAC:    if (tap == LAST_TAP) state_nxt = S_WAIT_Y;
         S_WAIT_Y: if (y_take) state_nxt = ((cnt + DATA_W'(1)) == len) ? S_DONE : S_WAIT_X;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) state <= S_IDLE;
      else           state <= state_nxt;
   end

   // Bus handshake and register file; ap_done set takes priority over read-clear
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         ap_done   <= 1'b0;
         len       <= '0;
         for (int i = 0; i < NTAP; i++) coef[i] <= '0;
      end else begin
         wbs_ack_o <= accept;
         wbs_dat_o <= (accept && !wbs_we_i) ? rdata : '0;
         if (len_wr)  len <= wbs_dat_i[DATA_W-1:0];
         if (coef_wr) coef[coef_idx] <= wbs_dat_i[DATA_W-1:0];
         if (state == S_DONE)
            ap_done <= 1'b1;
         else if (ctrl_rd || (start && len != '0))
            ap_done <= 1'b0;
      end
   end

   // Sample history, tap sweep with wrapping accumulate, and the per-job sample counter
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         for (int i = 0; i < NTAP; i++) hist[i] <= '0;
         cnt    <= '0;
         acc    <= '0;
         result <= '0;
         tap    <= '0;
      end else begin
         if (start && len != '0) begin
            for (int i = 0; i < NTAP; i++) hist[i] <= '0;
            cnt <= '0;
         end
         if (x_take) begin
            hist[0] <= wbs_dat_i[DATA_W-1:0];
            for (int i = 1; i < NTAP; i++) hist[i] <= hist[i-1];
            acc <= '0;
            tap <= '0;
         end
         if (state == S_MAC) begin
            if (tap == LAST_TAP) begin
               result <= acc;
            end else begin
               acc <= acc + prod;
               tap <= tap + TAP_W'(1);
            end
         end
         if (y_take) cnt <= cnt + DATA_W'(1);
      end
   end
endmodule

// File: tb/tb_wb_fir_engine.sv
// tb/tb_wb_fir_engine.sv - self-checking bench for wb_fir_engine
module tb_wb_fir_engine;
   localparam int          NTAP   = 11;
   localparam logic [31:0] BASE   = 32'h3000_0000;
   localparam logic [31:0] A_CTRL = BASE + 32'h00;
   localparam logic [31:0] A_LEN  = BASE + 32'h10;
   localparam logic [31:0] A_COEF = BASE + 32'h40;
   localparam logic [31:0] A_X    = BASE + 32'h80;
   localparam logic [31:0] A_Y    = BASE + 32'h84;

   logic        clk = 1'b0;
   logic        rst_n, cyc, stb, we, ack, irq;
   logic [3:0]  sel;
   logic [31:0] adr, wdat, rdat;

   int          n_assert = 0;
   int          n_fail = 0;
   int          cyc_no = 0;
   int          last_waits, last_ack_at;
   logic [31:0] last_y;
   logic [31:0] m_coef [NTAP];
   logic [31:0] m_xq [$];
   logic [31:0] seq_y [5] = '{32'd0, 32'd1, 32'd4, 32'd10, 32'd20};

   wb_fir_engine #(.DATA_W(32), .NTAP(NTAP), .BASE_ADDR(BASE)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst_n),
      .wbs_cyc_i (cyc),
      .wbs_stb_i (stb),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_adr_i (adr),
      .wbs_dat_i (wdat),
      .wbs_ack_o (ack),
      .wbs_dat_o (rdat),
      .irq_o     (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_no <= cyc_no + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: y = sum over taps of coef[i] * (i-th most recent sample), low 32 bits
   function automatic logic [31:0] model_y();
      longint s;
      s = 0;
      for (int i = 0; i < NTAP; i++)
         if (i < m_xq.size())
            s += longint'(signed'(m_coef[i])) * longint'(signed'(m_xq[i]));
      return s[31:0];
   endfunction

   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd_data);
      bit got;
      @(posedge clk); #1;
      check("ack_single", 32'(ack), 32'd0);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
      got = 1'b0; last_waits = 0; rd_data = '0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(posedge clk); #1;
         last_waits++;
         if (ack) begin
            got = 1'b1;
            rd_data = rdat;
            last_ack_at = cyc_no;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0; wdat = '0;
      check("ack_timeout", 32'(got), 32'd1);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] dummy;
      xfer(1'b1, a, d, dummy);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      xfer(1'b0, a, 32'd0, d);
   endtask

   task automatic set_coefs();
      for (int i = 0; i < NTAP; i++) wr(A_COEF + 32'(4 * i), m_coef[i]);
   endtask

   // mode 0: X = 1,2,3..; mode 1: random X; mode 2: X = xfix
   task automatic run_job(input int n, input int mode, input logic [31:0] xfix, input bit probe);
      logic [31:0] x, y, r;
      int x_at;
      wr(A_LEN, 32'(n));
      m_xq.delete();
      wr(A_CTRL, 32'h1);
      for (int k = 0; k < n; k++) begin
         if (probe && k == 1) begin
            rd(A_CTRL, r);
            check("ctrl_wait_x", r, 32'h10);
            rd(A_LEN, r);
            check("len_busy_read", r, 32'd0);
            wr(A_COEF, 32'd99);
            wr(A_CTRL, 32'h1);
         end
         x = (mode == 0) ? 32'(k + 1) : (mode == 1) ? $urandom : xfix;
         wr(A_X, x);
         check("x_wait_states", 32'(last_waits), 32'd1);
         x_at = last_ack_at;
         m_xq.push_front(x);
         if (m_xq.size() > NTAP) void'(m_xq.pop_back());
         rd(A_Y, y);
         check("y_value", y, model_y());
         // Y is accepted in the first y_valid cycle and acked one cycle later
         check("x_to_y_valid", 32'(last_ack_at - x_at - 1), 32'(NTAP + 1));
         if (mode == 0 && k < 5) check("y_table", y, seq_y[k]);
         last_y = y;
      end
   endtask

   initial begin
      logic [31:0] r;
      int n;
      bit bad;
      rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF; adr = '0; wdat = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_dat", rdat, 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      rst_n = 1'b1;

      rd(A_CTRL, r); check("ctrl_reset", r, 32'h4);
      rd(A_LEN, r);  check("len_reset", r, 32'd0);
      rd(A_COEF, r); check("coef0_reset", r, 32'd0);

      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4000_0084;
      bad = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (ack !== 1'b0 || rdat !== 32'd0) bad = 1'b1;
      end
      cyc = 1'b0; stb = 1'b0;
      check("unselected_quiet", 32'(bad), 32'd0);

      wr(BASE + 32'h20, 32'hDEAD_BEEF);
      rd(BASE + 32'h20, r); check("unmapped_read", r, 32'd0);
      wr(A_COEF + 32'(4 * NTAP), 32'h1234);
      rd(A_COEF + 32'(4 * NTAP), r); check("coef_past_ntap", r, 32'd0);

      for (int i = 0; i < NTAP; i++) m_coef[i] = 32'(i);
      set_coefs();
      rd(A_COEF + 32'd12, r); check("coef3_readback", r, 32'd3);
      run_job(5, 0, 32'd0, 1'b0);
      @(posedge clk); #1;
      check("irq_done", 32'(irq), 32'd1);
      rd(A_CTRL, r); check("ctrl_done", r, 32'h6);
      check("irq_cleared", 32'(irq), 32'd0);
      rd(A_CTRL, r); check("ctrl_after_clear", r, 32'h4);
      rd(A_Y, r); check("y_idle_last", r, 32'd20);
      wr(A_X, 32'h55); check("x_idle_acked", 32'(last_waits), 32'd1);

      for (int i = 0; i < NTAP; i++) m_coef[i] = 32'd0;
      m_coef[0] = 32'h7FFF_FFFF;
      set_coefs();
      run_job(1, 2, 32'd2, 1'b0);
      check("wrap_pos", last_y, 32'hFFFF_FFFE);
      rd(A_CTRL, r); check("ctrl_done_wrap", r, 32'h6);
      m_coef[0] = 32'hFFFF_FFFF;
      wr(A_COEF, m_coef[0]);
      run_job(1, 2, 32'd3, 1'b0);
      check("neg_coef", last_y, 32'hFFFF_FFFD);
      rd(A_CTRL, r); check("ctrl_done_neg", r, 32'h6);

      for (int i = 0; i < NTAP; i++) m_coef[i] = $urandom;
      set_coefs();
      run_job(4, 1, 32'd0, 1'b1);
      rd(A_COEF, r); check("coef0_kept", r, m_coef[0]);
      rd(A_CTRL, r); check("ctrl_done_rand", r, 32'h6);
      run_job(13, 1, 32'd0, 1'b0);
      rd(A_CTRL, r); check("ctrl_done_long", r, 32'h6);

      wr(A_LEN, 32'd0);
      wr(A_CTRL, 32'h1);
      n = 0;
      for (int i = 1; i <= 4 && n == 0; i++) begin
         @(posedge clk); #1;
         if (irq) n = i;
      end
      check("len0_done_seen", 32'(n != 0), 32'd1);
      check("len0_done_within_2", 32'(n <= 2), 32'd1);
      rd(A_CTRL, r); check("ctrl_done_len0", r, 32'h6);

      for (int i = 0; i < NTAP; i++) m_coef[i] = 32'(i);
      set_coefs();
      wr(A_LEN, 32'd5);
      wr(A_CTRL, 32'h1);
      wr(A_X, 32'd7);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_Y;
      bad = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         if (ack) bad = 1'b1;
      end
      rst_n = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (ack || rdat !== 32'd0 || irq) bad = 1'b1;
      end
      cyc = 1'b0; stb = 1'b0; rst_n = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         if (ack) bad = 1'b1;
      end
      check("reset_abort_no_ack", 32'(bad), 32'd0);
      rd(A_CTRL, r); check("ctrl_after_reset", r, 32'h4);
      rd(A_COEF + 32'd20, r); check("coef5_after_reset", r, 32'd0);
      rd(A_Y, r); check("y_after_reset", r, 32'd0);
      set_coefs();
      run_job(5, 0, 32'd0, 1'b0);
      rd(A_CTRL, r); check("ctrl_done_rerun", r, 32'h6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
